// File: rtl/switch_allocator_pkg.sv
// ============================================================================
// Module : switch_allocator_pkg
// Brief  : Shared flit-id encodings, port indices and allocator FSM state type.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package switch_allocator_pkg;

    localparam logic [2:0] HEADER = 3'b001;
    localparam logic [2:0] BODY   = 3'b010;
    localparam logic [2:0] TAIL   = 3'b100;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_W = 2;
    localparam int PORT_S = 3;
    localparam int PORT_L = 4;

    localparam logic [2:0] OWNER_NONE = 3'd7;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/switch_allocator_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; first request at or after ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NPORT = 5
) (
    input  logic [NPORT-1:0] req_i,
    input  logic [2:0]       ptr_i,
    output logic [NPORT-1:0] grant_o
);

    logic found;
    int   idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NPORT; k++) begin
            idx = (int'(ptr_i) + k) % NPORT;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/switch_allocator.sv
// ============================================================================
// Module : switch_allocator
// Brief  : Per-output wormhole switch allocator with round-robin arbitration.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int NPORT = 5,
    parameter int FW    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT-1:0]       in_valid,
    input  logic [NPORT*FW-1:0]    in_flit_id,
    input  logic [NPORT*NPORT-1:0] route_req,
    input  logic [NPORT-1:0]       out_credit,
    output logic [NPORT-1:0]       in_read,
    output logic [NPORT-1:0]       out_valid,
    output logic [NPORT*3-1:0]     xbar_sel,
    output logic [NPORT-1:0]       req_err
);

    state_t     state_q [NPORT];
    state_t     state_d [NPORT];
    logic [2:0] owner_q [NPORT];
    logic [2:0] owner_d [NPORT];
    logic [2:0] rr_q    [NPORT];
    logic [2:0] rr_d    [NPORT];
    logic [NPORT-1:0] req_err_q, req_err_d;

    logic [NPORT-1:0] w_is_head, w_is_tail, w_onehot, w_owned;
    logic [NPORT-1:0] w_src_valid, w_src_tail, w_xfer;
    logic [NPORT-1:0] w_elig  [NPORT];
    logic [NPORT-1:0] w_grant [NPORT];

    // Ownership is derived from registered state only, so all outputs can
    // arbitrate in the same cycle without combinational feedback.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            w_is_head[i] = in_valid[i] && (in_flit_id[FW*i +: FW] == FW'(HEADER));
            w_is_tail[i] = (in_flit_id[FW*i +: FW] == FW'(TAIL));
            w_onehot[i]  = $onehot(route_req[NPORT*i +: NPORT]);
            w_owned[i]   = 1'b0;
            for (int j = 0; j < NPORT; j++) begin
                if (state_q[j] == ST_BUSY && owner_q[j] == 3'(i)) begin
                    w_owned[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NPORT; j++) begin
            w_elig[j] = '0;
            for (int i = 0; i < NPORT; i++) begin
                w_elig[j][i] = (state_q[j] == ST_IDLE) && w_is_head[i] && w_onehot[i]
                             && route_req[NPORT*i + j] && !w_owned[i];
            end
        end
    end

    for (genvar j = 0; j < NPORT; j++) begin : g_arb
        rr_arbiter #(.NPORT(NPORT)) u_arb (
            .req_i   (w_elig[j]),
            .ptr_i   (rr_q[j]),
            .grant_o (w_grant[j])
        );
    end

    always_comb begin
        for (int j = 0; j < NPORT; j++) begin
            w_src_valid[j] = 1'b0;
            w_src_tail[j]  = 1'b0;
            for (int i = 0; i < NPORT; i++) begin
                if (owner_q[j] == 3'(i)) begin
                    w_src_valid[j] = in_valid[i];
                    w_src_tail[j]  = w_is_tail[i];
                end
            end
            w_xfer[j] = !rst && (state_q[j] == ST_BUSY) && w_src_valid[j] && out_credit[j];

            state_d[j] = state_q[j];
            owner_d[j] = owner_q[j];
            rr_d[j]    = rr_q[j];
            if (state_q[j] == ST_IDLE) begin
                for (int i = 0; i < NPORT; i++) begin
                    if (w_grant[j][i]) begin
                        state_d[j] = ST_BUSY;
                        owner_d[j] = 3'(i);
                    end
                end
            end else if (w_xfer[j] && w_src_tail[j]) begin
                state_d[j] = ST_IDLE;
                owner_d[j] = OWNER_NONE;
                rr_d[j]    = (owner_q[j] == 3'(NPORT-1)) ? 3'd0 : owner_q[j] + 3'd1;
            end
        end
    end

    always_comb begin
        req_err_d = req_err_q;
        for (int i = 0; i < NPORT; i++) begin
            in_read[i] = 1'b0;
            for (int j = 0; j < NPORT; j++) begin
                if (w_xfer[j] && owner_q[j] == 3'(i)) begin
                    in_read[i] = 1'b1;
                end
            end
            if (w_is_head[i]) begin
                req_err_d[i] = !w_onehot[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NPORT; j++) begin
                state_q[j] <= ST_IDLE;
                owner_q[j] <= OWNER_NONE;
                rr_q[j]    <= 3'd0;
            end
            req_err_q <= '0;
        end else begin
            for (int j = 0; j < NPORT; j++) begin
                state_q[j] <= state_d[j];
                owner_q[j] <= owner_d[j];
                rr_q[j]    <= rr_d[j];
            end
            req_err_q <= req_err_d;
        end
    end

    always_comb begin
        for (int j = 0; j < NPORT; j++) begin
            xbar_sel[3*j +: 3] = owner_q[j];
        end
    end

    assign out_valid = w_xfer;
    assign req_err   = req_err_q;

endmodule

`default_nettype wire

// File: tb/tb_switch_allocator.sv
// ============================================================================
// Module : tb_switch_allocator
// Brief  : Directed self-checking bench for switch_allocator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_switch_allocator;

    localparam logic [2:0] H = 3'b001;
    localparam logic [2:0] B = 3'b010;
    localparam logic [2:0] T = 3'b100;
    localparam logic [14:0] ALL_FREE = 15'h7fff;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  in_valid;
    logic [14:0] in_flit_id;
    logic [24:0] route_req;
    logic [4:0]  out_credit;
    logic [4:0]  in_read;
    logic [4:0]  out_valid;
    logic [14:0] xbar_sel;
    logic [4:0]  req_err;

    int n_cmp  = 0;
    int n_fail = 0;

    switch_allocator #(.NPORT(5), .FW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_flit_id (in_flit_id),
        .route_req  (route_req),
        .out_credit (out_credit),
        .in_read    (in_read),
        .out_valid  (out_valid),
        .xbar_sel   (xbar_sel),
        .req_err    (req_err)
    );

    always #5 clk = ~clk;

    task automatic set_in(input int i, input logic v, input logic [2:0] f, input logic [4:0] r);
        in_valid[i]          = v;
        in_flit_id[3*i +: 3] = f;
        route_req[5*i +: 5]  = r;
    endtask

    task automatic clear_inputs;
        in_valid   = '0;
        in_flit_id = '0;
        route_req  = '0;
        out_credit = '1;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid   = '1;
        in_flit_id = {5{B}};
        route_req  = {5{5'b00001}};
        out_credit = '1;
        #2;
        n_cmp++; if (in_read !== 5'b0) begin n_fail++; $display("FAIL reset_in_read got %b exp 00000", in_read); end
        n_cmp++; if (out_valid !== 5'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 00000", out_valid); end
        next_cycle();
        #2;
        n_cmp++; if (xbar_sel !== ALL_FREE) begin n_fail++; $display("FAIL reset_xbar got %h exp %h", xbar_sel, ALL_FREE); end
        n_cmp++; if (req_err !== 5'b0) begin n_fail++; $display("FAIL reset_req_err got %b exp 00000", req_err); end
        n_cmp++; if (in_read !== 5'b0) begin n_fail++; $display("FAIL reset_hold_read got %b exp 00000", in_read); end
        next_cycle();
        rst = 1'b0;
        clear_inputs();
    endtask

    // Input 0 -> E, H/B/T, then rr_ptr[E]=1 picks input 1 over input 0.
    task automatic test_basic;
        do_reset();
        set_in(0, 1, H, 5'b00010); #2;
        n_cmp++; if (in_read !== 5'b0) begin n_fail++; $display("FAIL basic_grant_cycle got %b exp 00000", in_read); end
        n_cmp++; if (xbar_sel !== ALL_FREE) begin n_fail++; $display("FAIL basic_pre_grant_xbar got %h exp %h", xbar_sel, ALL_FREE); end
        next_cycle(); #2;
        n_cmp++; if (xbar_sel[5:3] !== 3'd0) begin n_fail++; $display("FAIL basic_xbar_E got %0d exp 0", xbar_sel[5:3]); end
        n_cmp++; if (in_read !== 5'b00001) begin n_fail++; $display("FAIL basic_read_head got %b exp 00001", in_read); end
        n_cmp++; if (out_valid !== 5'b00010) begin n_fail++; $display("FAIL basic_ovalid_head got %b exp 00010", out_valid); end
        next_cycle(); set_in(0, 1, B, 5'b00000); #2;
        n_cmp++; if (in_read !== 5'b00001) begin n_fail++; $display("FAIL basic_read_body got %b exp 00001", in_read); end
        next_cycle(); set_in(0, 1, T, 5'b00000); #2;
        n_cmp++; if (out_valid !== 5'b00010) begin n_fail++; $display("FAIL basic_ovalid_tail got %b exp 00010", out_valid); end
        next_cycle();
        set_in(0, 1, H, 5'b00010);
        set_in(1, 1, H, 5'b00010); #2;
        n_cmp++; if (xbar_sel[5:3] !== 3'd7) begin n_fail++; $display("FAIL basic_E_idle got %0d exp 7", xbar_sel[5:3]); end
        n_cmp++; if (in_read !== 5'b0) begin n_fail++; $display("FAIL basic_idle_read got %b exp 00000", in_read); end
        next_cycle(); #2;
        n_cmp++; if (xbar_sel[5:3] !== 3'd1) begin n_fail++; $display("FAIL basic_rr_next got %0d exp 1", xbar_sel[5:3]); end
        n_cmp++; if (in_read !== 5'b00010) begin n_fail++; $display("FAIL basic_rr_read got %b exp 00010", in_read); end
        clear_inputs();
    endtask

    task automatic test_rr_contention;
        do_reset();
        set_in(1, 1, H, 5'b10000);
        set_in(3, 1, H, 5'b10000); #2;
        n_cmp++; if (in_read !== 5'b0) begin n_fail++; $display("FAIL rr_grant_cycle got %b exp 00000", in_read); end
        next_cycle(); #2;
        n_cmp++; if (xbar_sel[14:12] !== 3'd1) begin n_fail++; $display("FAIL rr_first_owner got %0d exp 1", xbar_sel[14:12]); end
        n_cmp++; if (in_read !== 5'b00010) begin n_fail++; $display("FAIL rr_first_read got %b exp 00010", in_read); end
        next_cycle(); set_in(1, 1, T, 5'b00000); #2;
        n_cmp++; if (in_read !== 5'b00010) begin n_fail++; $display("FAIL rr_tail1_read got %b exp 00010", in_read); end
        next_cycle(); set_in(1, 0, B, 5'b00000); #2;
        n_cmp++; if (xbar_sel[14:12] !== 3'd7) begin n_fail++; $display("FAIL rr_L_idle got %0d exp 7", xbar_sel[14:12]); end
        n_cmp++; if (in_read !== 5'b0) begin n_fail++; $display("FAIL rr_regrant_cycle got %b exp 00000", in_read); end
        next_cycle(); #2;
        n_cmp++; if (xbar_sel[14:12] !== 3'd3) begin n_fail++; $display("FAIL rr_second_owner got %0d exp 3", xbar_sel[14:12]); end
        n_cmp++; if (out_valid !== 5'b10000) begin n_fail++; $display("FAIL rr_second_ovalid got %b exp 10000", out_valid); end
        clear_inputs();
    endtask

    task automatic test_credit_stall;
        do_reset();
        set_in(4, 1, H, 5'b01000);
        next_cycle(); #2;
        n_cmp++; if (in_read !== 5'b10000) begin n_fail++; $display("FAIL stall_head_read got %b exp 10000", in_read); end
        next_cycle();
        set_in(4, 1, B, 5'b00000);
        out_credit[3] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #2;
            n_cmp++; if (in_read !== 5'b0 || out_valid !== 5'b0) begin n_fail++; $display("FAIL stall_c%0d got rd=%b ov=%b exp 00000/00000", c, in_read, out_valid); end
            n_cmp++; if (xbar_sel[11:9] !== 3'd4) begin n_fail++; $display("FAIL stall_owner_c%0d got %0d exp 4", c, xbar_sel[11:9]); end
            next_cycle();
        end
        out_credit[3] = 1'b1; #2;
        n_cmp++; if (in_read !== 5'b10000) begin n_fail++; $display("FAIL stall_resume got %b exp 10000", in_read); end
        next_cycle(); set_in(4, 1, T, 5'b00000); #2;
        n_cmp++; if (out_valid !== 5'b01000) begin n_fail++; $display("FAIL stall_tail got %b exp 01000", out_valid); end
        next_cycle(); set_in(4, 0, B, 5'b00000); #2;
        n_cmp++; if (xbar_sel[11:9] !== 3'd7) begin n_fail++; $display("FAIL stall_S_idle got %0d exp 7", xbar_sel[11:9]); end
        clear_inputs();
    endtask

    task automatic test_req_err;
        do_reset();
        set_in(2, 1, H, 5'b00011); #2;
        n_cmp++; if (req_err !== 5'b0) begin n_fail++; $display("FAIL err_before got %b exp 00000", req_err); end
        next_cycle();
        set_in(2, 1, H, 5'b00100); #2;
        n_cmp++; if (req_err !== 5'b00100) begin n_fail++; $display("FAIL err_set got %b exp 00100", req_err); end
        n_cmp++; if (xbar_sel !== ALL_FREE) begin n_fail++; $display("FAIL err_no_grant got %h exp %h", xbar_sel, ALL_FREE); end
        n_cmp++; if (in_read !== 5'b0) begin n_fail++; $display("FAIL err_no_read got %b exp 00000", in_read); end
        next_cycle(); #2;
        n_cmp++; if (req_err !== 5'b0) begin n_fail++; $display("FAIL err_clear got %b exp 00000", req_err); end
        n_cmp++; if (xbar_sel[8:6] !== 3'd2) begin n_fail++; $display("FAIL err_valid_grant got %0d exp 2", xbar_sel[8:6]); end
        clear_inputs();
    endtask

    task automatic test_reset_abort;
        do_reset();
        set_in(1, 1, H, 5'b00001);
        next_cycle(); #2;
        n_cmp++; if (xbar_sel[2:0] !== 3'd1) begin n_fail++; $display("FAIL abort_owner got %0d exp 1", xbar_sel[2:0]); end
        next_cycle(); set_in(1, 1, B, 5'b00000); #2;
        n_cmp++; if (in_read !== 5'b00010) begin n_fail++; $display("FAIL abort_body_read got %b exp 00010", in_read); end
        next_cycle(); rst = 1'b1; #2;
        n_cmp++; if (in_read !== 5'b0 || out_valid !== 5'b0) begin n_fail++; $display("FAIL abort_during_rst got rd=%b ov=%b exp 00000/00000", in_read, out_valid); end
        next_cycle(); rst = 1'b0; #2;
        n_cmp++; if (xbar_sel !== ALL_FREE) begin n_fail++; $display("FAIL abort_xbar got %h exp %h", xbar_sel, ALL_FREE); end
        n_cmp++; if (in_read !== 5'b0) begin n_fail++; $display("FAIL abort_no_read got %b exp 00000", in_read); end
        clear_inputs();
        set_in(0, 1, H, 5'b00010);
        set_in(4, 1, H, 5'b00010);
        next_cycle(); #2;
        n_cmp++; if (xbar_sel[5:3] !== 3'd0) begin n_fail++; $display("FAIL abort_rr_zero got %0d exp 0", xbar_sel[5:3]); end
        clear_inputs();
    endtask

    task automatic test_busy_header;
        do_reset();
        set_in(2, 1, H, 5'b00100);
        next_cycle(); #2;
        n_cmp++; if (xbar_sel[8:6] !== 3'd2) begin n_fail++; $display("FAIL bh_owner_W got %0d exp 2", xbar_sel[8:6]); end
        next_cycle(); set_in(2, 1, H, 5'b00010); #2;
        n_cmp++; if (out_valid !== 5'b00100) begin n_fail++; $display("FAIL bh_fwd_as_data got %b exp 00100", out_valid); end
        next_cycle(); set_in(2, 1, B, 5'b00010); #2;
        n_cmp++; if (xbar_sel[5:3] !== 3'd7) begin n_fail++; $display("FAIL bh_E_not_granted got %0d exp 7", xbar_sel[5:3]); end
        next_cycle(); set_in(2, 1, T, 5'b00010); #2;
        n_cmp++; if (in_read !== 5'b00100) begin n_fail++; $display("FAIL bh_tail_read got %b exp 00100", in_read); end
        next_cycle(); set_in(2, 1, H, 5'b00010); #2;
        n_cmp++; if (xbar_sel[8:6] !== 3'd7 || in_read !== 5'b0) begin n_fail++; $display("FAIL bh_W_release got sel=%0d rd=%b exp 7/00000", xbar_sel[8:6], in_read); end
        next_cycle(); #2;
        n_cmp++; if (xbar_sel[5:3] !== 3'd2) begin n_fail++; $display("FAIL bh_E_granted got %0d exp 2", xbar_sel[5:3]); end
        n_cmp++; if (out_valid !== 5'b00010) begin n_fail++; $display("FAIL bh_E_ovalid got %b exp 00010", out_valid); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic();
        test_rr_contention();
        test_credit_stall();
        test_req_err();
        test_reset_abort();
        test_busy_header();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter NPORT, default 5, meaning the number of router ports; index order is N=0, E=1, W=2, S=3, L=4.
REQ-002 SHALL have parameter FW, default 3, meaning the flit_id width.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  NPORT  input FIFO i non-empty (~empty).
REQ-006 SHALL have port in_flit_id  input  NPORT*FW  flit_id of input i head flit, at bits [FW*i +: FW].
REQ-007 SHALL have port route_req  input  NPORT*NPORT  LBDR port bits of input i, at bits [NPORT*i +: NPORT]; bit j requests output j.
REQ-008 SHALL have port out_credit  input  NPORT  output j downstream can accept one flit this cycle.
REQ-009 SHALL have port in_read  output  NPORT  pop input FIFO i; combinational.
REQ-010 SHALL have port out_valid  output  NPORT  flit presented on output j this cycle; combinational.
REQ-011 SHALL have port xbar_sel  output  NPORT*3  registered input index owning output j, at bits [3*j +: 3]; 3'd7 when the output is free.
REQ-012 SHALL have port req_err  output  NPORT  registered flag: input i presented a HEADER with route_req not one-hot.

Function
REQ-013 SHALL keep one FSM per output j with states IDLE and BUSY, plus a 3-bit owner register and a 3-bit round-robin pointer rr_ptr.
REQ-014 In IDLE, input i SHALL be eligible for output j when in_valid[i]=1, in_flit_id[i]=HEADER, route_req of input i is one-hot with bit j set, and input i owns no other output.
REQ-015 IDLE arbitration SHALL grant the first eligible input found searching rr_ptr, rr_ptr+1, ... modulo NPORT.
REQ-016 On a grant, the output SHALL move to BUSY at the next edge with owner=granted index; grant latency is exactly 1 cycle.
REQ-017 No flit SHALL transfer in the grant cycle.
REQ-018 In BUSY, out_valid[j] and in_read[owner] SHALL both equal in_valid[owner] & out_credit[j]; the HEADER flit is therefore the first flit transferred.
REQ-019 A transfer whose flit_id is TAIL SHALL return the output to IDLE at the next edge and set rr_ptr=(owner+1) mod NPORT.
REQ-020 A transfer whose flit_id is TAIL SHALL NOT be held with a stall.
REQ-021 With in_valid=0 or out_credit=0, BUSY SHALL hold, with no transfer and no state change.
REQ-022 Ownership SHALL be exclusive: each input is owned by at most one output, and each output by at most one input.
REQ-023 Outputs SHALL arbitrate in the same cycle independently; the REQ-014 ownership check uses registered state only.
REQ-024 A HEADER with zero or multiple route_req bits SHALL be ignored for arbitration.
REQ-025 Such a HEADER SHALL set req_err[i] at the next edge; req_err[i] clears at the next edge where input i presents a valid one-hot HEADER.
REQ-026 A HEADER arriving at an input while it owns an output SHALL be forwarded as data; it SHALL NOT restart arbitration.
REQ-027 in_read and out_valid SHALL be 0 for every output in IDLE.

Reset
REQ-028 rst SHALL force all outputs to IDLE, owner to 7, rr_ptr to 0, xbar_sel to all 3'd7 and req_err to 0, at the next edge.
REQ-029 rst SHALL override any in-flight packet (mid-packet abort).
REQ-030 In_read and out_valid SHALL be 0 during any cycle in which rst=1.

Structure
REQ-031 The shared parameters package SHALL hold the flit_id constants HEADER=3'b001, BODY=3'b010 and TAIL=3'b100.
REQ-032 The shared parameters package SHALL hold the port index constants N/E/W/S/L and the typedef for the FSM state.
REQ-033 One sub-module rr_arbiter (NPORT requests, pointer in, one-hot grant out, combinational) SHALL be instantiated once per output.

Verification
REQ-034 Scenario: input 0 sends a HEADER with route_req=E (5'b00010), then BODY and TAIL, out_credit all 1 -> xbar_sel[E]=0 one cycle after the HEADER; in_read[0] high 3 cycles; E returns to IDLE and rr_ptr[E]=1.
REQ-035 Scenario: inputs 1 and 3 both request L in the same cycle with rr_ptr=0 -> input 1 is granted; after its TAIL, input 3 is granted on the next cycle.
REQ-036 Scenario: credit stall, out_credit[S]=0 for 4 cycles mid-packet -> no in_read and no out_valid; state stays BUSY, owner unchanged; resumes when credit returns.
REQ-037 Scenario: HEADER with route_req=5'b00011 -> no grant; req_err[i]=1 at the next edge; cleared by a later valid one-hot HEADER.
REQ-038 Scenario: rst asserted while N is BUSY after the BODY flit -> next cycle N is IDLE, xbar_sel[N]=7, rr_ptr=0, and no in_read.
REQ-039 Scenario: input 2 owns W and its in_flit_id shows a HEADER requesting E -> E does not grant input 2 until W has seen the TAIL of input 2.
